// File: rtl/updown_modcount_if.sv
// Control/data bundle for updown_modcount. With UPDOWN_MODCOUNT_CMP_EN defined it also
// carries the compare value and the match flag.
interface updown_modcount_if #(
    parameter int unsigned N = 8
);
    logic         L;
    logic         E;
    logic         up_down;
    logic         sat;
    logic [N-1:0] step;
    logic [N-1:0] R;
    logic [N-1:0] Q;
    logic         tc;
    logic         at_lim;
`ifdef UPDOWN_MODCOUNT_CMP_EN
    logic [N-1:0] cmp_val;
    logic         match;

    modport master (output L, E, up_down, sat, step, R, cmp_val,
                    input  Q, tc, at_lim, match);
    modport slave  (input  L, E, up_down, sat, step, R, cmp_val,
                    output Q, tc, at_lim, match);
`else
    modport master (output L, E, up_down, sat, step, R,
                    input  Q, tc, at_lim);
    modport slave  (input  L, E, up_down, sat, step, R,
                    output Q, tc, at_lim);
`endif
endinterface

// File: rtl/updown_modcount.sv
// Up/down modulo-(MAX+1) counter with load, step, wrap/saturate and registered terminal count.
// Optional compare/match output is built when UPDOWN_MODCOUNT_CMP_EN is defined.
module updown_modcount #(
    parameter int unsigned N   = 8,
    parameter int unsigned MAX = (1 << N) - 1
) (
    input logic              Clock,
    input logic              Resetn,
    updown_modcount_if.slave bus
);
    localparam logic [N:0]   MaxW = (N+1)'(MAX);
    localparam logic [N:0]   ModW = (N+1)'(MAX + 1);
    localparam logic [N-1:0] MaxN = N'(MAX);

    logic [N-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic [N:0]   q_ext, step_ext, r_ext, s, r_cl, sum;

    // N+1-bit arithmetic: Q+s <= 2*MAX and Q+MAX+1 <= 2*MAX+1 never overflow.
    always_comb begin
        q_ext    = {1'b0, q_q};
        step_ext = {1'b0, bus.step};
        r_ext    = {1'b0, bus.R};
        s        = (step_ext > MaxW) ? MaxW : step_ext;
        r_cl     = (r_ext > MaxW) ? MaxW : r_ext;
        sum      = q_ext + s;
    end

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (bus.L) begin
            q_d = N'(r_cl);
        end else if (bus.E && (s != '0)) begin
            if (bus.up_down) begin
                if (sum <= MaxW) begin
                    q_d = N'(sum);
                end else if (!bus.sat) begin
                    q_d  = N'(sum - ModW);
                    tc_d = 1'b1;
                end else begin
                    q_d  = MaxN;
                    tc_d = (q_q != MaxN);
                end
            end else begin
                if (s <= q_ext) begin
                    q_d = N'(q_ext - s);
                end else if (!bus.sat) begin
                    q_d  = N'(q_ext + ModW - s);
                    tc_d = 1'b1;
                end else begin
                    q_d  = '0;
                    tc_d = (q_q != '0);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.tc     = tc_q;
    assign bus.at_lim = bus.up_down ? (q_q == MaxN) : (q_q == '0);

`ifdef UPDOWN_MODCOUNT_CMP_EN
    logic match_q, match_d;

    // Compare against next Q so match lines up with the Q it describes.
    always_comb begin
        match_d = (q_d == bus.cmp_val);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign bus.match = match_q;
`endif
endmodule

// File: tb/tb_updown_modcount.sv
// Scoreboard bench for updown_modcount: three instances (N=8/MAX=255, N=4/MAX=9, N=8/MAX=99).
module tb_updown_modcount;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   seq    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    updown_modcount_if #(.N(8)) if0 ();
    updown_modcount_if #(.N(4)) if1 ();
    updown_modcount_if #(.N(8)) if2 ();

    updown_modcount #(.N(8), .MAX(255)) u0 (.Clock(clk), .Resetn(rst_n), .bus(if0));
    updown_modcount #(.N(4), .MAX(9))   u1 (.Clock(clk), .Resetn(rst_n), .bus(if1));
    updown_modcount #(.N(8), .MAX(99))  u2 (.Clock(clk), .Resetn(rst_n), .bus(if2));

    typedef struct {
        int       id;
        int       num;
        int       due;
        logic [7:0] q;
        logic     tc;
        logic     lim;
        logic     chk_m;
        logic     m;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic drive_idle();
        if0.L = 0; if0.E = 0; if0.up_down = 0; if0.sat = 0; if0.step = '0; if0.R = '0;
        if1.L = 0; if1.E = 0; if1.up_down = 0; if1.sat = 0; if1.step = '0; if1.R = '0;
        if2.L = 0; if2.E = 0; if2.up_down = 0; if2.sat = 0; if2.step = '0; if2.R = '0;
    endtask

    // Drive one DUT for the next edge and queue its expected post-edge outputs.
    task automatic apply(input int id, input logic l, input logic e, input logic ud,
                         input logic st, input logic [7:0] stp, input logic [7:0] r,
                         input logic [7:0] xq, input logic xtc, input logic xlim,
                         input logic chkm, input logic xm);
        exp_t ent;
        @(posedge clk);
        #4;
        drive_idle();
        case (id)
            0: begin if0.L = l; if0.E = e; if0.up_down = ud; if0.sat = st;
                     if0.step = stp; if0.R = r; end
            1: begin if1.L = l; if1.E = e; if1.up_down = ud; if1.sat = st;
                     if1.step = stp[3:0]; if1.R = r[3:0]; end
            default: begin if2.L = l; if2.E = e; if2.up_down = ud; if2.sat = st;
                     if2.step = stp; if2.R = r; end
        endcase
        ent.id = id; ent.num = seq; ent.due = cyc + 1;
        ent.q = xq; ent.tc = xtc; ent.lim = xlim; ent.chk_m = chkm; ent.m = xm;
        seq++;
        sb.push_back(ent);
    endtask

    task automatic check_now(input string nm, input logic [7:0] act, input logic [7:0] xp);
        n_vec++;
        if (act !== xp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, xp);
        end
    endtask

    // Monitor: a few ns after each edge, pop every entry due by now and compare.
    always @(posedge clk) begin
        logic [7:0] aq;
        logic atc, alim, am;
        #3;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            am = 1'b0;
            case (mon_e.id)
                0: begin aq = if0.Q; atc = if0.tc; alim = if0.at_lim; end
                1: begin aq = {4'b0, if1.Q}; atc = if1.tc; alim = if1.at_lim;
`ifdef UPDOWN_MODCOUNT_CMP_EN
                         am = if1.match;
`endif
                   end
                default: begin aq = if2.Q; atc = if2.tc; alim = if2.at_lim; end
            endcase
`ifndef UPDOWN_MODCOUNT_CMP_EN
            mon_e.chk_m = 1'b0;
`endif
            n_vec++;
            if (aq !== mon_e.q || atc !== mon_e.tc || alim !== mon_e.lim ||
                (mon_e.chk_m && am !== mon_e.m)) begin
                n_bad++;
                $display("FAIL vec%0d dut%0d: Q=%0d tc=%0d lim=%0d m=%0d, expected Q=%0d tc=%0d lim=%0d m=%0d",
                         mon_e.num, mon_e.id, aq, atc, alim, am,
                         mon_e.q, mon_e.tc, mon_e.lim, mon_e.m);
            end
        end
    end

    initial begin
        drive_idle();
`ifdef UPDOWN_MODCOUNT_CMP_EN
        if0.cmp_val = '0; if1.cmp_val = 4'd3; if2.cmp_val = '0;
`endif
        #3;
        check_now("reset_q", if0.Q, 8'd0);
        check_now("reset_tc", {7'b0, if0.tc}, 8'd0);
        #4 rst_n = 1'b1;

        //   id L  E  ud sat step  R      Q    tc lim cm m
        apply(0, 1, 0, 1, 0, 8'd0, 8'h0C, 8'd12, 0, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 8'd1, 8'h00, 8'd13, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 8'd0, 8'd254, 8'd254, 0, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 8'd3, 8'h00, 8'd1, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 1, 8'd1, 8'h00, 8'd0, 0, 1, 0, 0);
        // Decade wrap
        apply(1, 1, 0, 1, 0, 8'd0, 8'd7, 8'd7, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd8, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd9, 0, 1, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd0, 1, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd1, 0, 0, 0, 0);
        // Saturate down
        apply(1, 1, 0, 0, 1, 8'd0, 8'd5, 8'd5, 0, 0, 0, 0);
        apply(1, 0, 1, 0, 1, 8'd3, 8'd0, 8'd2, 0, 0, 0, 0);
        apply(1, 0, 1, 0, 1, 8'd3, 8'd0, 8'd0, 1, 1, 0, 0);
        apply(1, 0, 1, 0, 1, 8'd3, 8'd0, 8'd0, 0, 1, 0, 0);
        // Load priority with clamp, then wrap past MAX
        apply(1, 1, 1, 1, 0, 8'd2, 8'hF, 8'd9, 0, 1, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd2, 8'd0, 8'd1, 1, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd15, 8'd0, 8'd0, 1, 0, 0, 0);
        // Saturate up, then pinned at MAX
        apply(1, 1, 0, 1, 1, 8'd0, 8'd8, 8'd8, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 1, 8'd5, 8'd0, 8'd9, 1, 1, 0, 0);
        apply(1, 0, 1, 1, 1, 8'd5, 8'd0, 8'd9, 0, 1, 0, 0);
        apply(1, 0, 0, 1, 1, 8'd5, 8'd0, 8'd9, 0, 1, 0, 0);
        // Large-step wrap on MAX=99
        apply(2, 1, 0, 0, 0, 8'd0, 8'd5, 8'd5, 0, 0, 0, 0);
        apply(2, 0, 1, 0, 0, 8'd200, 8'd0, 8'd6, 1, 0, 0, 0);
        apply(2, 0, 1, 0, 0, 8'd0, 8'd0, 8'd6, 0, 0, 0, 0);
        apply(2, 1, 0, 1, 0, 8'd0, 8'd200, 8'd99, 0, 1, 0, 0);
        // Leave tc pending, then reset between edges
        apply(1, 1, 0, 1, 0, 8'd0, 8'd8, 8'd8, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 8'd3, 8'd0, 8'd1, 1, 0, 0, 0);
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check_now("midrst_q", {4'b0, if1.Q}, 8'd0);
        check_now("midrst_tc", {7'b0, if1.tc}, 8'd0);
        check_now("midrst_q2", if2.Q, 8'd0);
        drive_idle();
        #2 rst_n = 1'b1;
        // Count up from 0; match follows Q==3
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd1, 0, 0, 1, 0);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd2, 0, 0, 1, 0);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd3, 0, 0, 1, 1);
        apply(1, 0, 1, 1, 0, 8'd1, 8'd0, 8'd4, 0, 0, 1, 0);
        apply(1, 1, 0, 1, 0, 8'd0, 8'd3, 8'd3, 0, 0, 1, 1);

        @(posedge clk);
        #4 drive_idle();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #5;
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/updown_modcount.md
Name: updown_modcount

Overview:
- Parametrised successor to the team's 8-bit up/down counter with parallel load.
- Adds a programmable modulus (0..MAX), a per-cycle step size, a wrap/saturate mode select, and a registered terminal-count pulse.
- Used standalone or cascaded (tc of one stage driving E of the next) as a decade, timer or position counter in lab designs.

Parameters:
- N, 8, counter width in bits.
- MAX, 2**N-1, largest count value; must satisfy 1 <= MAX <= 2**N-1; counting range is 0..MAX.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- L  input  1  synchronous parallel load; has priority over E.
- E  input  1  count enable.
- up_down  input  1  direction: 1 = up, 0 = down.
- sat  input  1  mode: 1 = saturate at the limits, 0 = wrap modulo MAX+1.
- step  input  N  increment per enabled cycle.
- R  input  N  parallel load value.
- Q  output  N  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- at_lim  output  1  combinational: 1 when Q==MAX and up_down==1, or when Q==0 and up_down==0.

Interface decided: one clock (Clock); reset (Resetn) is asynchronous and active-low.

Behaviour:
- Reset: Resetn=0 forces Q=0 and tc=0 immediately, independent of Clock. Deassertion takes effect from the next rising edge.
- Priority each rising edge: L, then E, then hold.
- Load (L=1):
  - Q <= min(R, MAX); tc <= 0.
  - E, up_down, sat and step are ignored.
- Step clamp: the effective step is s = min(step, MAX). All arithmetic uses N+1 bits, so no intermediate overflow is possible.
- Count up (E=1, L=0, up_down=1):
  - If Q+s <= MAX: Q <= Q+s; tc <= 0.
  - Otherwise, wrap mode (sat=0): Q <= Q+s-(MAX+1); tc <= 1.
  - Otherwise, saturate mode (sat=1): Q <= MAX; tc <= 1, but only if Q != MAX beforehand. A counter already pinned at MAX gives tc=0.
- Count down (E=1, L=0, up_down=0):
  - If s <= Q: Q <= Q-s; tc <= 0.
  - Otherwise, wrap mode (sat=0): Q <= Q+(MAX+1)-s; tc <= 1.
  - Otherwise, saturate mode (sat=1): Q <= 0; tc <= 1, but only if Q != 0 beforehand.
- Zero step (s==0): Q holds; tc <= 0.
- Hold (E=0, L=0): Q holds; tc <= 0.
- tc timing: tc is high for exactly the one cycle following the edge at which the boundary was crossed, aligned with the new Q.
- Latency: 1 clock from input sampling to Q/tc.
- Mid-cycle changes: up_down and sat may change on any cycle; the value sampled at the edge governs that edge.
- Reset mid-count: Q drops to 0 asynchronously; any pending tc is cleared.

Optional Feature:
- Macro: UPDOWN_MODCOUNT_CMP_EN.
- Defined:
  - Adds input cmp_val [N-1:0] and registered output match.
  - At each edge, match <= (next Q == cmp_val), so match is aligned with Q.
  - match reset value is 0; loads are included in the comparison.
- Undefined: cmp_val and match ports are absent; no comparator logic is built.

Test Plan:
- Reset/load: Resetn=0 at t=0, then 1 at 7 ns; L=1 with R=8'h0C, N=8, MAX=255 -> Q=0 during reset; Q=12 one edge after L; tc=0 throughout.
- Decade wrap (N=4, MAX=9, sat=0, up_down=1, step=1, E=1, starting from Q=7) -> Q sequence 8, 9, 0, 1; tc=1 only in the cycle where Q=0.
- Saturate down (MAX=9, sat=1, up_down=0, step=3, Q=5) -> Q=2, then 0 with tc=1, then 0 with tc=0 on further edges; at_lim=1 while Q=0.
- Load priority and clamp (MAX=9, L=1 and E=1 together, R=4'hF) -> Q=9, tc=0; next edge with L=0, up, sat=0, step=2 -> Q=1, tc=1.
- Large-step wrap (N=8, MAX=99, sat=0, Q=5, down, step=200) -> s=99, Q=5+100-99=6, tc=1; step=0 with E=1 -> Q holds at 6, tc=0.
- Async reset mid-count: Resetn pulled low between edges while counting -> Q=0 and tc=0 before the next edge; with UPDOWN_MODCOUNT_CMP_EN defined and cmp_val=3, counting up from 0 gives match=1 exactly when Q=3.
